// File: rtl/physics_pkg.sv
// Shared types and helpers for the soft-body point updater.
// Holds the FSM state type, obstacle index width and sat_resize.
package physics_pkg;

  localparam int NUM_OBSTACLES = 5;
  localparam int OBS_W = $clog2(NUM_OBSTACLES);

  typedef enum logic [2:0] {
    IDLE,
    VEL,
    REQ,
    WAIT,
    POS,
    DONE
  } state_e;

  // Fit a wide signed sum into w bits. With UPDATE_POINT_SAT_EN
  // the value clamps to the signed range, otherwise it wraps.
  // The result is sign-extended back to 32 bits.
  function automatic logic signed [31:0] sat_resize(
    input logic signed [31:0] v,
    input int                 w
  );
`ifdef UPDATE_POINT_SAT_EN
    logic signed [31:0] mx;
    logic signed [31:0] mn;
    mx = (32'sd1 <<< (w - 1)) - 32'sd1;
    mn = -mx - 32'sd1;
    if (v > mx) return mx;
    if (v < mn) return mn;
    return v;
`else
    logic [31:0] m;
    logic [31:0] r;
    m = (32'd1 << w) - 32'd1;
    r = v & m;
    if (r[w-1]) r = r | ~m;
    return signed'(r);
`endif
  endfunction

endpackage

// File: rtl/point_integrate.sv
// Combinational per-point arithmetic: force->velocity, contact damping
// and free position integration. Ports: *_i operands, *_o results.
module point_integrate
  import physics_pkg::*;
#(
  parameter int POSITION_SIZE = 16,
  parameter int VELOCITY_SIZE = 16,
  parameter int FORCE_SIZE    = 16,
  parameter int DT_SHIFT      = 0,
  parameter int MASS_SHIFT    = 2,
  parameter int DAMP_SHIFT    = 2
) (
  input  logic [VELOCITY_SIZE-1:0] vel_x_i,
  input  logic [VELOCITY_SIZE-1:0] vel_y_i,
  input  logic [FORCE_SIZE-1:0]    force_x_i,
  input  logic [FORCE_SIZE-1:0]    force_y_i,
  input  logic [VELOCITY_SIZE-1:0] cur_vx_i,
  input  logic [VELOCITY_SIZE-1:0] cur_vy_i,
  input  logic [POSITION_SIZE-1:0] cur_px_i,
  input  logic [POSITION_SIZE-1:0] cur_py_i,
  output logic [VELOCITY_SIZE-1:0] vf_x_o,
  output logic [VELOCITY_SIZE-1:0] vf_y_o,
  output logic [VELOCITY_SIZE-1:0] vd_x_o,
  output logic [VELOCITY_SIZE-1:0] vd_y_o,
  output logic [POSITION_SIZE-1:0] pn_x_o,
  output logic [POSITION_SIZE-1:0] pn_y_o
);

  logic signed [31:0] vx, vy, fx, fy;
  logic signed [31:0] cvx, cvy, cpx, cpy;

  assign vx  = 32'(signed'(vel_x_i));
  assign vy  = 32'(signed'(vel_y_i));
  assign fx  = 32'(signed'(force_x_i));
  assign fy  = 32'(signed'(force_y_i));
  assign cvx = 32'(signed'(cur_vx_i));
  assign cvy = 32'(signed'(cur_vy_i));
  assign cpx = 32'(signed'(cur_px_i));
  assign cpy = 32'(signed'(cur_py_i));

  assign vf_x_o = VELOCITY_SIZE'(
    sat_resize(vx + (fx >>> MASS_SHIFT), VELOCITY_SIZE));
  assign vf_y_o = VELOCITY_SIZE'(
    sat_resize(vy + (fy >>> MASS_SHIFT), VELOCITY_SIZE));

  assign vd_x_o = VELOCITY_SIZE'(
    sat_resize(cvx - (cvx >>> DAMP_SHIFT), VELOCITY_SIZE));
  assign vd_y_o = VELOCITY_SIZE'(
    sat_resize(cvy - (cvy >>> DAMP_SHIFT), VELOCITY_SIZE));

  assign pn_x_o = POSITION_SIZE'(
    sat_resize(cpx + (cvx >>> DT_SHIFT), POSITION_SIZE));
  assign pn_y_o = POSITION_SIZE'(
    sat_resize(cpy + (cvy >>> DT_SHIFT), POSITION_SIZE));

endmodule

// File: rtl/multi_point_updater.sv
// Updates all mass points per step via a shared collision checker.
// Ports: begin/latched inputs, col_* handshake, new_* results, flags.
// Option: UPDATE_POINT_SAT_EN selects saturating resize.
module multi_point_updater
  import physics_pkg::*;
#(
  parameter int NUM_POINTS    = 8,
  parameter int POSITION_SIZE = 16,
  parameter int VELOCITY_SIZE = 16,
  parameter int FORCE_SIZE    = 16,
  parameter int DT_SHIFT      = 0,
  parameter int MASS_SHIFT    = 2,
  parameter int DAMP_SHIFT    = 2,
  parameter int MAX_ITERS     = 4
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic begin_in,
  input  logic [OBS_W:0] num_obstacles_in,
  input  logic [NUM_POINTS-1:0][POSITION_SIZE-1:0] pos_x_in,
  input  logic [NUM_POINTS-1:0][POSITION_SIZE-1:0] pos_y_in,
  input  logic [NUM_POINTS-1:0][VELOCITY_SIZE-1:0] vel_x_in,
  input  logic [NUM_POINTS-1:0][VELOCITY_SIZE-1:0] vel_y_in,
  input  logic [NUM_POINTS-1:0][FORCE_SIZE-1:0]    force_x_in,
  input  logic [NUM_POINTS-1:0][FORCE_SIZE-1:0]    force_y_in,
  output logic col_req_out,
  output logic [OBS_W-1:0] col_obstacle_out,
  output logic [POSITION_SIZE-1:0] col_pos_x_out,
  output logic [POSITION_SIZE-1:0] col_pos_y_out,
  output logic [VELOCITY_SIZE-1:0] col_vel_x_out,
  output logic [VELOCITY_SIZE-1:0] col_vel_y_out,
  input  logic col_done_in,
  input  logic col_hit_in,
  input  logic [POSITION_SIZE-1:0] col_x_in,
  input  logic [POSITION_SIZE-1:0] col_y_in,
  output logic [NUM_POINTS-1:0][POSITION_SIZE-1:0] new_pos_x,
  output logic [NUM_POINTS-1:0][POSITION_SIZE-1:0] new_pos_y,
  output logic [NUM_POINTS-1:0][VELOCITY_SIZE-1:0] new_vel_x,
  output logic [NUM_POINTS-1:0][VELOCITY_SIZE-1:0] new_vel_y,
  output logic [NUM_POINTS-1:0] hit_flags_out,
  output logic iter_limit_out,
  output logic busy_out,
  output logic result_out
);

  localparam int PW = (NUM_POINTS > 1) ? $clog2(NUM_POINTS) : 1;
  localparam int IW = $clog2(MAX_ITERS + 1);
  localparam logic [PW-1:0] P_LAST = PW'(NUM_POINTS - 1);
  localparam logic [IW-1:0] I_LAST = IW'(MAX_ITERS - 1);

  state_e state_q;

  logic [PW-1:0]    p_q;
  logic [OBS_W-1:0] k_q;
  logic [OBS_W:0]   nobs_q;
  logic [IW-1:0]    iter_q;
  logic             any_hit_q;

  logic [NUM_POINTS-1:0][POSITION_SIZE-1:0] lpx_q, lpy_q;
  logic [NUM_POINTS-1:0][VELOCITY_SIZE-1:0] lvx_q, lvy_q;
  logic [NUM_POINTS-1:0][FORCE_SIZE-1:0]    lfx_q, lfy_q;

  // Working copy of the point being processed.
  logic [POSITION_SIZE-1:0] cpx_q, cpy_q;
  logic [VELOCITY_SIZE-1:0] cvx_q, cvy_q;

  logic                     col_req_q;
  logic [OBS_W-1:0]         col_obs_q;
  logic [POSITION_SIZE-1:0] col_px_q, col_py_q;
  logic [VELOCITY_SIZE-1:0] col_vx_q, col_vy_q;

  logic [NUM_POINTS-1:0][POSITION_SIZE-1:0] npx_q, npy_q;
  logic [NUM_POINTS-1:0][VELOCITY_SIZE-1:0] nvx_q, nvy_q;
  logic [NUM_POINTS-1:0] hit_q;
  logic iter_lim_q, busy_q, result_q;

  logic [VELOCITY_SIZE-1:0] vf_x, vf_y, vd_x, vd_y;
  logic [POSITION_SIZE-1:0] pn_x, pn_y;

  point_integrate #(
    .POSITION_SIZE(POSITION_SIZE),
    .VELOCITY_SIZE(VELOCITY_SIZE),
    .FORCE_SIZE   (FORCE_SIZE),
    .DT_SHIFT     (DT_SHIFT),
    .MASS_SHIFT   (MASS_SHIFT),
    .DAMP_SHIFT   (DAMP_SHIFT)
  ) u_integ (
    .vel_x_i  (lvx_q[p_q]),
    .vel_y_i  (lvy_q[p_q]),
    .force_x_i(lfx_q[p_q]),
    .force_y_i(lfy_q[p_q]),
    .cur_vx_i (cvx_q),
    .cur_vy_i (cvy_q),
    .cur_px_i (cpx_q),
    .cur_py_i (cpy_q),
    .vf_x_o   (vf_x),
    .vf_y_o   (vf_y),
    .vd_x_o   (vd_x),
    .vd_y_o   (vd_y),
    .pn_x_o   (pn_x),
    .pn_y_o   (pn_y)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      p_q        <= '0;
      k_q        <= '0;
      nobs_q     <= '0;
      iter_q     <= '0;
      any_hit_q  <= 1'b0;
      lpx_q      <= '0;
      lpy_q      <= '0;
      lvx_q      <= '0;
      lvy_q      <= '0;
      lfx_q      <= '0;
      lfy_q      <= '0;
      cpx_q      <= '0;
      cpy_q      <= '0;
      cvx_q      <= '0;
      cvy_q      <= '0;
      col_req_q  <= 1'b0;
      col_obs_q  <= '0;
      col_px_q   <= '0;
      col_py_q   <= '0;
      col_vx_q   <= '0;
      col_vy_q   <= '0;
      npx_q      <= '0;
      npy_q      <= '0;
      nvx_q      <= '0;
      nvy_q      <= '0;
      hit_q      <= '0;
      iter_lim_q <= 1'b0;
      busy_q     <= 1'b0;
      result_q   <= 1'b0;
    end else begin
      result_q  <= 1'b0;
      col_req_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (begin_in) begin
            lpx_q      <= pos_x_in;
            lpy_q      <= pos_y_in;
            lvx_q      <= vel_x_in;
            lvy_q      <= vel_y_in;
            lfx_q      <= force_x_in;
            lfy_q      <= force_y_in;
            nobs_q     <= num_obstacles_in;
            p_q        <= '0;
            busy_q     <= 1'b1;
            iter_lim_q <= 1'b0;
            state_q    <= VEL;
          end
        end
        VEL: begin
          cvx_q     <= vf_x;
          cvy_q     <= vf_y;
          cpx_q     <= lpx_q[p_q];
          cpy_q     <= lpy_q[p_q];
          iter_q    <= '0;
          k_q       <= '0;
          any_hit_q <= 1'b0;
          state_q   <= (nobs_q != '0) ? REQ : POS;
        end
        REQ: begin
          col_req_q <= 1'b1;
          col_obs_q <= k_q;
          col_px_q  <= cpx_q;
          col_py_q  <= cpy_q;
          col_vx_q  <= cvx_q;
          col_vy_q  <= cvy_q;
          state_q   <= WAIT;
        end
        WAIT: begin
          if (col_done_in) begin
            if (col_hit_in) begin
              cpx_q     <= col_x_in;
              cpy_q     <= col_y_in;
              any_hit_q <= 1'b1;
              if (iter_q == I_LAST) begin
                iter_lim_q <= 1'b1;
                state_q    <= POS;
              end else begin
                // A correction may push the point into an
                // earlier obstacle, so rescan from the start.
                iter_q  <= iter_q + 1'b1;
                k_q     <= '0;
                state_q <= REQ;
              end
            end else if ({1'b0, k_q} == nobs_q - 1'b1) begin
              state_q <= POS;
            end else begin
              k_q     <= k_q + 1'b1;
              state_q <= REQ;
            end
          end
        end
        POS: begin
          if (any_hit_q) begin
            npx_q[p_q] <= cpx_q;
            npy_q[p_q] <= cpy_q;
            nvx_q[p_q] <= vd_x;
            nvy_q[p_q] <= vd_y;
          end else begin
            npx_q[p_q] <= pn_x;
            npy_q[p_q] <= pn_y;
            nvx_q[p_q] <= cvx_q;
            nvy_q[p_q] <= cvy_q;
          end
          hit_q[p_q] <= any_hit_q;
          if (p_q == P_LAST) begin
            state_q <= DONE;
          end else begin
            p_q     <= p_q + 1'b1;
            state_q <= VEL;
          end
        end
        DONE: begin
          result_q <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign col_req_out      = col_req_q;
  assign col_obstacle_out = col_obs_q;
  assign col_pos_x_out    = col_px_q;
  assign col_pos_y_out    = col_py_q;
  assign col_vel_x_out    = col_vx_q;
  assign col_vel_y_out    = col_vy_q;
  assign new_pos_x        = npx_q;
  assign new_pos_y        = npy_q;
  assign new_vel_x        = nvx_q;
  assign new_vel_y        = nvy_q;
  assign hit_flags_out    = hit_q;
  assign iter_limit_out   = iter_lim_q;
  assign busy_out         = busy_q;
  assign result_out       = result_q;

endmodule

// File: tb/tb_multi_point_updater.sv
// Directed bench for multi_point_updater with two points and a
// scripted collision checker model.
module tb_multi_point_updater;

  localparam int NP = 2;
  localparam int OW = physics_pkg::OBS_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic begin_in = 1'b0;
  logic [OW:0] nobs = '0;
  logic [NP-1:0][15:0] px, py, vx, vy, fx, fy;
  logic col_req;
  logic [OW-1:0] col_obs;
  logic [15:0] col_px, col_py, col_vx, col_vy;
  logic col_done = 1'b0;
  logic col_hit = 1'b0;
  logic [15:0] col_x = '0;
  logic [15:0] col_y = '0;
  logic [NP-1:0][15:0] npx, npy, nvx, nvy;
  logic [NP-1:0] hits;
  logic ilim, busy, res;

  int total = 0;
  int bad = 0;

  // Checker model: 0 miss, 1 obstacle 1 hits once, 2 always hit,
  // 3 silent.
  int chk_mode = 0;
  bit hit_used = 0;
  int req_cnt = 0;
  int lg_obs[64];
  int lg_px[64];
  int lg_vx[64];

  multi_point_updater #(
    .NUM_POINTS(NP)
  ) dut (
    .clk_in          (clk),
    .rst_in          (rst_n),
    .begin_in        (begin_in),
    .num_obstacles_in(nobs),
    .pos_x_in        (px),
    .pos_y_in        (py),
    .vel_x_in        (vx),
    .vel_y_in        (vy),
    .force_x_in      (fx),
    .force_y_in      (fy),
    .col_req_out     (col_req),
    .col_obstacle_out(col_obs),
    .col_pos_x_out   (col_px),
    .col_pos_y_out   (col_py),
    .col_vel_x_out   (col_vx),
    .col_vel_y_out   (col_vy),
    .col_done_in     (col_done),
    .col_hit_in      (col_hit),
    .col_x_in        (col_x),
    .col_y_in        (col_y),
    .new_pos_x       (npx),
    .new_pos_y       (npy),
    .new_vel_x       (nvx),
    .new_vel_y       (nvy),
    .hit_flags_out   (hits),
    .iter_limit_out  (ilim),
    .busy_out        (busy),
    .result_out      (res)
  );

  always #5 clk = ~clk;

  always begin
    @(posedge clk);
    #1;
    if (col_req && rst_n) begin
      bit h;
      if (req_cnt < 64) begin
        lg_obs[req_cnt] = int'(col_obs);
        lg_px[req_cnt]  = int'($signed(col_px));
        lg_vx[req_cnt]  = int'($signed(col_vx));
      end
      req_cnt++;
      h = 0;
      if (chk_mode == 2) h = 1;
      if (chk_mode == 1 && col_obs == 1 && !hit_used) begin
        h = 1;
        hit_used = 1;
      end
      if (chk_mode != 3) begin
        @(posedge clk);
        #1;
        col_done = 1'b1;
        col_hit  = h;
        if (chk_mode == 1) begin
          col_x = 16'd40;
          col_y = 16'd40;
        end else begin
          col_x = 16'(req_cnt * 10);
          col_y = 16'(req_cnt * 10 + 1);
        end
        @(posedge clk);
        #1;
        col_done = 1'b0;
        col_hit  = 1'b0;
      end
    end
  end

  task automatic set_pt(input int i, input int ipx, input int ipy,
                        input int ivx, input int ivy,
                        input int ifx, input int ify);
    px[i] = 16'(ipx);
    py[i] = 16'(ipy);
    vx[i] = 16'(ivx);
    vy[i] = 16'(ivy);
    fx[i] = 16'(ifx);
    fy[i] = 16'(ify);
  endtask

  task automatic run_step(input string nm, output int cyc,
                          output bit busy1, output bit busy_end);
    bit ok;
    ok = 0;
    cyc = 0;
    busy1 = 0;
    busy_end = 1;
    req_cnt = 0;
    hit_used = 0;
    begin_in = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      begin_in = 1'b0;
      cyc++;
      if (cyc == 1) busy1 = busy;
      if (res) begin
        busy_end = busy;
        ok = 1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s_timeout got=no_result want=result", nm);
    end
  endtask

  task automatic chk(input string nm, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic test_reset;
    if (npx[0] !== 16'd0) begin
      bad++;
      $display("FAIL rst_npx got=%0d want=0", npx[0]);
    end
    total++;
    if (busy !== 1'b0 || res !== 1'b0) begin
      bad++;
      $display("FAIL rst_busy got=%b%b want=00", busy, res);
    end
    total++;
    if (col_req !== 1'b0 || hits !== 2'b00 || ilim !== 1'b0) begin
      bad++;
      $display("FAIL rst_flags got=%b%b%b want=000",
               col_req, hits, ilim);
    end
    total++;
  endtask

  task automatic test_no_obstacles;
    int c;
    bit b1, be;
    chk_mode = 0;
    nobs = '0;
    set_pt(0, 100, 50, 3, -2, 8, 0);
    set_pt(1, -10, 20, -4, 7, -9, 5);
    run_step("noobs", c, b1, be);
    chk("noobs_latency", c, 6);
    chk("noobs_busy1", int'(b1), 1);
    chk("noobs_busy_end", int'(be), 0);
    chk("noobs_p0x", int'($signed(npx[0])), 105);
    chk("noobs_p0y", int'($signed(npy[0])), 48);
    chk("noobs_v0x", int'($signed(nvx[0])), 5);
    chk("noobs_v0y", int'($signed(nvy[0])), -2);
    chk("noobs_p1x", int'($signed(npx[1])), -17);
    chk("noobs_p1y", int'($signed(npy[1])), 28);
    chk("noobs_v1x", int'($signed(nvx[1])), -7);
    chk("noobs_v1y", int'($signed(nvy[1])), 8);
    chk("noobs_hits", int'(hits), 0);
    chk("noobs_reqs", req_cnt, 0);
    @(posedge clk);
    #1;
    chk("noobs_pulse", int'(res), 0);
  endtask

  task automatic test_all_miss;
    int c;
    bit b1, be;
    chk_mode = 0;
    nobs = 4'd3;
    set_pt(0, 0, 0, 1, 1, 0, 0);
    set_pt(1, 200, -300, -5, 10, 4, -4);
    run_step("miss", c, b1, be);
    chk("miss_reqs", req_cnt, 6);
    for (int i = 0; i < 6; i++)
      chk("miss_obs", lg_obs[i], i % 3);
    chk("miss_req_px", lg_px[3], 200);
    chk("miss_req_vx", lg_vx[3], -4);
    chk("miss_p0x", int'($signed(npx[0])), 1);
    chk("miss_p1x", int'($signed(npx[1])), 196);
    chk("miss_p1y", int'($signed(npy[1])), -291);
    chk("miss_v1y", int'($signed(nvy[1])), 9);
    chk("miss_hits", int'(hits), 0);
  endtask

  task automatic test_single_hit;
    int c;
    bit b1, be;
    int exp_obs[8] = '{0, 1, 0, 1, 2, 0, 1, 2};
    chk_mode = 1;
    nobs = 4'd3;
    set_pt(0, 10, 10, 8, 0, 0, 0);
    set_pt(1, 0, 0, 0, 0, 0, 0);
    run_step("hit1", c, b1, be);
    chk("hit1_reqs", req_cnt, 8);
    for (int i = 0; i < 8; i++)
      chk("hit1_obs", lg_obs[i], exp_obs[i]);
    chk("hit1_p0x", int'($signed(npx[0])), 40);
    chk("hit1_p0y", int'($signed(npy[0])), 40);
    chk("hit1_v0x", int'($signed(nvx[0])), 6);
    chk("hit1_v0y", int'($signed(nvy[0])), 0);
    chk("hit1_p1x", int'($signed(npx[1])), 0);
    chk("hit1_hits", int'(hits), 1);
    chk("hit1_ilim", int'(ilim), 0);
  endtask

  task automatic test_iter_limit;
    int c;
    bit b1, be;
    chk_mode = 2;
    nobs = 4'd2;
    set_pt(0, 5, 5, -8, 4, 0, 0);
    set_pt(1, 7, 7, 0, 100, 0, 0);
    run_step("ilim", c, b1, be);
    chk("ilim_reqs", req_cnt, 8);
    chk("ilim_flag", int'(ilim), 1);
    chk("ilim_p0x", int'($signed(npx[0])), 40);
    chk("ilim_p0y", int'($signed(npy[0])), 41);
    chk("ilim_v0x", int'($signed(nvx[0])), -6);
    chk("ilim_v0y", int'($signed(nvy[0])), 3);
    chk("ilim_p1x", int'($signed(npx[1])), 80);
    chk("ilim_p1y", int'($signed(npy[1])), 81);
    chk("ilim_v1y", int'($signed(nvy[1])), 75);
    chk("ilim_hits", int'(hits), 3);
    chk("ilim_obs3", lg_obs[3], 0);
  endtask

  task automatic test_resize;
    int c;
    bit b1, be;
    chk_mode = 0;
    nobs = '0;
    set_pt(0, 32760, 0, 20, 32767, 0, 100);
    set_pt(1, -32760, 0, -20, 0, 0, 0);
    run_step("rsz", c, b1, be);
`ifdef UPDATE_POINT_SAT_EN
    chk("rsz_p0x", int'($signed(npx[0])), 32767);
    chk("rsz_v0y", int'($signed(nvy[0])), 32767);
    chk("rsz_p0y", int'($signed(npy[0])), 32767);
    chk("rsz_p1x", int'($signed(npx[1])), -32768);
`else
    chk("rsz_p0x", int'($signed(npx[0])), -32756);
    chk("rsz_v0y", int'($signed(nvy[0])), -32744);
    chk("rsz_p0y", int'($signed(npy[0])), -32744);
    chk("rsz_p1x", int'($signed(npx[1])), 32756);
`endif
  endtask

  task automatic test_reset_mid_wait;
    bit seen;
    bit pulsed;
    int c;
    bit b1, be;
    chk_mode = 3;
    nobs = 4'd1;
    set_pt(0, 123, 9, 2, 2, 0, 0);
    set_pt(1, 1, 1, 0, 0, 0, 0);
    req_cnt = 0;
    seen = 0;
    begin_in = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      begin_in = 1'b0;
      if (col_req) begin
        seen = 1;
        break;
      end
    end
    chk("rmw_req_seen", int'(seen), 1);
    chk("rmw_req_px", int'($signed(col_px)), 123);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rmw_col_px", int'(col_px), 0);
    chk("rmw_busy", int'(busy), 0);
    chk("rmw_npx", int'(npx[0]), 0);
    chk("rmw_nvx", int'(nvx[1]), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    col_done = 1'b1;
    col_hit  = 1'b1;
    col_x    = 16'd77;
    col_y    = 16'd77;
    @(posedge clk);
    #1;
    col_done = 1'b0;
    col_hit  = 1'b0;
    pulsed = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (res || busy) pulsed = 1;
    end
    chk("rmw_no_result", int'(pulsed), 0);
    chk("rmw_npx_after", int'(npx[0]), 0);
    chk("rmw_hits_after", int'(hits), 0);
    chk_mode = 0;
    nobs = '0;
    set_pt(0, 100, 50, 3, -2, 8, 0);
    run_step("rmw_next", c, b1, be);
    chk("rmw_next_lat", c, 6);
    chk("rmw_next_p0x", int'($signed(npx[0])), 105);
    chk("rmw_next_v0x", int'($signed(nvx[0])), 5);
  endtask

  initial begin
    px = '0;
    py = '0;
    vx = '0;
    vy = '0;
    fx = '0;
    fy = '0;
    #22;
    test_reset;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_no_obstacles;
    test_all_miss;
    test_single_hit;
    test_iter_limit;
    test_resize;
    test_reset_mid_wait;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_point_updater.md
Name: multi_point_updater

Overview:
- Next-generation point updater for the soft-body car. One block updates all NUM_POINTS mass points per physics step: force-to-velocity integration, collision resolution against every obstacle, then position integration.
- Collision geometry is delegated to an external do_collision instance through a req/done handshake. One collision checker is shared across all points.
- New relative to the single-point updater: per-point forces, a bounded collision retry count, velocity damping on contact, and a per-point collision flag.

Parameters:
NUM_POINTS, 8, mass points updated per step
POSITION_SIZE, 16, signed position width
VELOCITY_SIZE, 16, signed velocity width
FORCE_SIZE, 16, signed force width
NUM_OBSTACLES, 5, max obstacles; index width OBS_W = $clog2(NUM_OBSTACLES)
DT_SHIFT, 0, dt = 2^-DT_SHIFT; pos += vel >>> DT_SHIFT
MASS_SHIFT, 2, vel += force >>> MASS_SHIFT
DAMP_SHIFT, 2, on contact vel -= vel >>> DAMP_SHIFT
MAX_ITERS, 4, max collision corrections per point

Ports:
clk_in  in  1  clock
rst_in  in  1  asynchronous, active-low reset
begin_in  in  1  start a step; sampled only in IDLE
num_obstacles_in  in  OBS_W+1  active obstacles, 0..NUM_OBSTACLES; latched at start
pos_x_in, pos_y_in  in  [NUM_POINTS][POSITION_SIZE]  current positions, latched at start
vel_x_in, vel_y_in  in  [NUM_POINTS][VELOCITY_SIZE]  current velocities, latched at start
force_x_in, force_y_in  in  [NUM_POINTS][FORCE_SIZE]  net force per point, latched at start
col_req_out  out  1  one-cycle pulse requesting a collision check
col_obstacle_out  out  OBS_W  obstacle index for the request
col_pos_x_out, col_pos_y_out  out  POSITION_SIZE  point under test
col_vel_x_out, col_vel_y_out  out  VELOCITY_SIZE  its velocity
col_done_in  in  1  one-cycle pulse: check complete
col_hit_in  in  1  valid with col_done_in: collision occurred
col_x_in, col_y_in  in  POSITION_SIZE  corrected position, valid when col_hit_in
new_pos_x, new_pos_y  out  [NUM_POINTS][POSITION_SIZE]  updated positions
new_vel_x, new_vel_y  out  [NUM_POINTS][VELOCITY_SIZE]  updated velocities
hit_flags_out  out  NUM_POINTS  bit i set if point i collided this step
iter_limit_out  out  1  some point hit MAX_ITERS this step
busy_out  out  1  high from the cycle after an accepted begin_in until result_out
result_out  out  1  one-cycle pulse: all outputs valid

Behaviour:
- Reset (rst_in=0, asynchronous): state IDLE. All outputs 0, including the col_* outputs, new_* arrays, flags, busy_out and result_out. A reset mid-step aborts the step; any col_done_in that arrives after reset is ignored in IDLE.
- Arithmetic: signed two's complement throughout; shifts are arithmetic. Sums use one guard bit, then go through the resize rule (see Optional Feature).
- IDLE: on begin_in, latch all inputs, set point index p=0, busy_out=1, go to VEL. begin_in while busy is ignored.
- VEL (1 cycle): v = v + (f >>> MASS_SHIFT); iter=0; obstacle index k=0; any_hit=0. Go to REQ if num_obstacles>0, else POS.
- REQ (1 cycle): drive col_* with point p and obstacle k, pulse col_req_out, go to WAIT. col_* data is held stable until col_done_in.
- WAIT: stall until col_done_in.
  - col_hit_in=1: pos = col_x/col_y, any_hit=1, iter++. If iter reaches MAX_ITERS, set iter_limit and go to POS. Otherwise k=0 and go to REQ (rescan all obstacles).
  - col_hit_in=0: if k == num_obstacles-1 go to POS, else k++ and go to REQ.
- POS (1 cycle):
  - any_hit=0: pos += vel >>> DT_SHIFT.
  - any_hit=1: vel -= vel >>> DAMP_SHIFT; position stays as corrected.
  - Write new_*[p]; hit_flags_out[p] = any_hit.
  - If p == NUM_POINTS-1 go to DONE, else p++ and go to VEL.
- DONE: pulse result_out for 1 cycle, busy_out=0, return to IDLE. Outputs hold until the next step writes them.
- Latency with no obstacles: 1 + 2*NUM_POINTS + 1 cycles after begin_in.
- Each collision check costs 1 (REQ) plus the checker latency.
- col_done_in outside WAIT is ignored.

Optional Feature:
- Macro: UPDATE_POINT_SAT_EN.
- Defined: every resize saturates to the destination signed range (e.g. POSITION_SIZE=16 gives 32767 / -32768).
- Undefined: resize truncates, i.e. wraps modulo 2^width.

Decomposition:
- Package physics_pkg holds:
  - typedef state enum {IDLE, VEL, REQ, WAIT, POS, DONE}
  - function sat_resize
  - localparam OBS_W
- Sub-module point_integrate: combinational velocity, damping and position arithmetic with the saturation option, instantiated once.
- FSM, point and obstacle indexing, and the handshake stay in the top module.

Test Plan:
- NUM_POINTS=2, num_obstacles=0, pos=(100,50), vel=(3,-2), force=(8,0), MASS_SHIFT=2 -> vel=(5,-2), pos=(105,48); result_out exactly 6 cycles after begin_in; hit_flags=0.
- num_obstacles=3, checker model always misses -> 3 col_req_out pulses per point with col_obstacle_out=0,1,2; positions integrate freely.
- Obstacle 1 hits once with (40,40), then all miss; vel=(8,0) -> new_pos=(40,40), new_vel=(6,0) (DAMP_SHIFT=2); hit_flags bit set; obstacles rescanned from 0.
- Checker always hits -> exactly MAX_ITERS=4 requests for the point; iter_limit_out=1; pos = last correction.
- UPDATE_POINT_SAT_EN defined, pos=32760, vel=20, no obstacles -> new_pos=32767; undefined -> -32756.
- Assert rst_in=0 while in WAIT, then release and deliver col_done_in -> outputs remain 0, no result_out; the next begin_in completes normally.
